encaps_hash_sequencer: RTL and testbench

//  Sequences the encapsulation hashing datapath.

---
 rtl/encaps_pkg.sv | 23 ++
 rtl/encaps_pad_gen.sv | 37 +++
 rtl/encaps_hash_sequencer.sv | 147 ++++++++++++++
 tb/tb_encaps_hash_sequencer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/encaps_pkg.sv
// Shared types and constants for the encapsulation hash sequencer.
// The state enum, the default sponge geometry and the SHA3 domain/pad bytes.
package encaps_pkg;

    localparam int RATE_BYTES     = 136;
    localparam int TRITS_PER_BYTE = 5;

    localparam logic [7:0] SHA3_PAD_FIRST = 8'h06;
    localparam logic [7:0] SHA3_PAD_LAST  = 8'h80;

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT,
        S_GATHER,
        S_PACK,
        S_SHIFT,
        S_ABSORB,
        S_WAIT,
        S_PAD,
        S_DONE
    } state_t;

endpackage

// File: rtl/encaps_pad_gen.sv
// SHA3 pad byte generator: counts shifted pad bytes and emits 06 / 00.. / 80,
// merging first and last into 86 when the pad is a single byte.
module encaps_pad_gen #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LEN_W-1:0] pad_len,
    input  logic             step,
    output logic [7:0]       pad_byte,
    output logic             pad_last
);
    import encaps_pkg::*;

    logic [LEN_W-1:0] cnt;
    logic             first;

    assign first    = (cnt == '0);
    assign pad_last = (cnt == pad_len - 1'b1);

    // Self-wrapping so the next message starts from the first pad byte again.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (step)
            cnt <= pad_last ? '0 : cnt + 1'b1;
    end

    always_comb begin
        pad_byte = 8'h00;
        if (first)
            pad_byte = pad_byte | SHA3_PAD_FIRST;
        if (pad_last)
            pad_byte = pad_byte | SHA3_PAD_LAST;
    end

endmodule

// File: rtl/encaps_hash_sequencer.sv
// Controller for the random-byte -> trit -> packed byte -> SHA3-256 absorb path.
// Drives single-clock enables for every datapath stage; no gated clocks.
module encaps_hash_sequencer #(
    parameter int MSG_BYTES      = 140,
    parameter int RATE_BYTES     = encaps_pkg::RATE_BYTES,
    parameter int TRITS_PER_BYTE = encaps_pkg::TRITS_PER_BYTE
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    output logic                               busy,
    output logic                               done,
    input  logic                               rnd_valid,
    output logic                               rnd_ready,
    output logic                               trit_en,
    output logic                               trit_clr,
    output logic                               pack_load,
    output logic                               blk_shift,
    output logic                               blk_clr,
    output logic                               pad_sel,
    output logic [7:0]                         pad_byte,
    output logic                               hash_init,
    output logic                               hash_start,
    output logic                               hash_last,
    input  logic                               hash_busy,
    output logic [$clog2(MSG_BYTES+1)-1:0]     byte_cnt
);
    import encaps_pkg::*;

    localparam int CNT_W   = $clog2(MSG_BYTES + 1);
    localparam int BLK_W   = $clog2(RATE_BYTES + 1);
    localparam int TRIT_W  = $clog2(TRITS_PER_BYTE + 1);
    localparam int PAD_LEN = (MSG_BYTES % RATE_BYTES == 0) ? RATE_BYTES
                                                           : RATE_BYTES - (MSG_BYTES % RATE_BYTES);

    state_t            state, next;
    logic [TRIT_W-1:0] trit_cnt;
    logic [BLK_W-1:0]  blk_cnt;
    logic              last_q;
    logic              wait_first;
    logic              trit_done;
    logic              blk_full;
    logic              msg_end;
    logic              pad_last;
    logic [7:0]        gen_byte;

    assign trit_done = trit_en && (trit_cnt == TRIT_W'(TRITS_PER_BYTE - 1));
    // Evaluated on the shifting cycle, i.e. before the counters advance.
    assign blk_full  = (blk_cnt == BLK_W'(RATE_BYTES - 1));
    assign msg_end   = (byte_cnt == CNT_W'(MSG_BYTES - 1));

    encaps_pad_gen #(.LEN_W(BLK_W)) u_pad_gen (
        .clk      (clk),
        .rst      (rst),
        .pad_len  (BLK_W'(PAD_LEN)),
        .step     (state == S_PAD),
        .pad_byte (gen_byte),
        .pad_last (pad_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= S_IDLE;
        else
            state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            S_IDLE:   if (start) next = S_INIT;
            S_INIT:   next = S_GATHER;
            S_GATHER: if (trit_done) next = S_PACK;
            S_PACK:   next = S_SHIFT;
            S_SHIFT: begin
                if (blk_full)     next = S_ABSORB;
                else if (msg_end) next = S_PAD;
                else              next = S_GATHER;
            end
            S_ABSORB: next = S_WAIT;
            S_WAIT: begin
                // The core raises hash_busy a cycle late, so the first WAIT cycle never exits.
                if (!wait_first && !hash_busy) begin
                    if (last_q)                                 next = S_DONE;
                    else if (byte_cnt == CNT_W'(MSG_BYTES))     next = S_PAD;
                    else                                        next = S_GATHER;
                end
            end
            S_PAD:    if (pad_last) next = S_ABSORB;
            S_DONE:   next = S_IDLE;
            default:  next = S_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != S_IDLE);
        rnd_ready  = (state == S_GATHER);
        trit_clr   = (state == S_INIT) || (state == S_SHIFT);
        pack_load  = (state == S_PACK);
        blk_shift  = (state == S_SHIFT) || (state == S_PAD);
        blk_clr    = (state == S_INIT) || ((state == S_WAIT) && wait_first);
        pad_sel    = (state == S_PAD);
        hash_init  = (state == S_INIT);
        hash_start = (state == S_ABSORB);
        done       = (state == S_DONE);
        pad_byte   = pad_sel ? gen_byte : 8'h00;
    end

    assign trit_en   = rnd_valid && rnd_ready;
    assign hash_last = last_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            trit_cnt   <= '0;
            blk_cnt    <= '0;
            byte_cnt   <= '0;
            last_q     <= 1'b0;
            wait_first <= 1'b0;
        end else begin
            wait_first <= (state == S_ABSORB);
            case (state)
                S_INIT: begin
                    trit_cnt <= '0;
                    blk_cnt  <= '0;
                    byte_cnt <= '0;
                    last_q   <= 1'b0;
                end
                S_GATHER: if (trit_en) trit_cnt <= trit_done ? '0 : trit_cnt + 1'b1;
                S_SHIFT: begin
                    trit_cnt <= '0;
                    blk_cnt  <= blk_cnt + 1'b1;
                    if (byte_cnt != CNT_W'(MSG_BYTES))
                        byte_cnt <= byte_cnt + 1'b1;
                end
                S_PAD: begin
                    blk_cnt <= blk_cnt + 1'b1;
                    if (pad_last)
                        last_q <= 1'b1;
                end
                S_ABSORB: blk_cnt <= '0;
                S_DONE:   last_q  <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_encaps_hash_sequencer.sv
// Directed bench: three sequencer instances (140/136, 8/8, 7/8) with a simple
// hash-core busy model and a negedge event monitor feeding per-run counters.
module tb_encaps_hash_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rnd_valid = 1'b1;
    logic [2:0] start = '0;
    logic [2:0] busy, done, rnd_ready, trit_en, trit_clr, pack_load, blk_shift, blk_clr;
    logic [2:0] pad_sel, hash_init, hash_start, hash_last, hash_busy;
    logic [7:0] pb [3];
    logic [7:0] bc_a;
    logic [3:0] bc_b;
    logic [2:0] bc_c;

    int busy_len = 24;
    int busy_cnt [3];
    int trit_c [3], pack_c [3], hs_c [3], pad_n [3], done_c [3], since [3];
    int init_c [3], viol_pack [3], viol_rdy [3];
    logic [7:0] pad_log [3][256];
    logic       hsl_log [3][4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    encaps_hash_sequencer u_a (
        .clk(clk), .rst(rst), .start(start[0]), .busy(busy[0]), .done(done[0]),
        .rnd_valid(rnd_valid), .rnd_ready(rnd_ready[0]), .trit_en(trit_en[0]),
        .trit_clr(trit_clr[0]), .pack_load(pack_load[0]), .blk_shift(blk_shift[0]),
        .blk_clr(blk_clr[0]), .pad_sel(pad_sel[0]), .pad_byte(pb[0]),
        .hash_init(hash_init[0]), .hash_start(hash_start[0]), .hash_last(hash_last[0]),
        .hash_busy(hash_busy[0]), .byte_cnt(bc_a));

    encaps_hash_sequencer #(.MSG_BYTES(8), .RATE_BYTES(8)) u_b (
        .clk(clk), .rst(rst), .start(start[1]), .busy(busy[1]), .done(done[1]),
        .rnd_valid(rnd_valid), .rnd_ready(rnd_ready[1]), .trit_en(trit_en[1]),
        .trit_clr(trit_clr[1]), .pack_load(pack_load[1]), .blk_shift(blk_shift[1]),
        .blk_clr(blk_clr[1]), .pad_sel(pad_sel[1]), .pad_byte(pb[1]),
        .hash_init(hash_init[1]), .hash_start(hash_start[1]), .hash_last(hash_last[1]),
        .hash_busy(hash_busy[1]), .byte_cnt(bc_b));

    encaps_hash_sequencer #(.MSG_BYTES(7), .RATE_BYTES(8)) u_c (
        .clk(clk), .rst(rst), .start(start[2]), .busy(busy[2]), .done(done[2]),
        .rnd_valid(rnd_valid), .rnd_ready(rnd_ready[2]), .trit_en(trit_en[2]),
        .trit_clr(trit_clr[2]), .pack_load(pack_load[2]), .blk_shift(blk_shift[2]),
        .blk_clr(blk_clr[2]), .pad_sel(pad_sel[2]), .pad_byte(pb[2]),
        .hash_init(hash_init[2]), .hash_start(hash_start[2]), .hash_last(hash_last[2]),
        .hash_busy(hash_busy[2]), .byte_cnt(bc_c));

    // Hash core stand-in: busy for busy_len cycles after each hash_start.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) busy_cnt[i] <= 0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (hash_start[i])        busy_cnt[i] <= busy_len;
                else if (busy_cnt[i] > 0) busy_cnt[i] <= busy_cnt[i] - 1;
            end
        end
    end
    assign hash_busy = {busy_cnt[2] != 0, busy_cnt[1] != 0, busy_cnt[0] != 0};

    initial begin
        for (int i = 0; i < 3; i++) begin
            trit_c[i] = 0; pack_c[i] = 0; hs_c[i] = 0; pad_n[i] = 0; done_c[i] = 0;
            since[i] = 0; init_c[i] = 0; viol_pack[i] = 0; viol_rdy[i] = 0;
        end
    end

    // Per-run event counters, restarted by hash_init.
    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                if (hash_init[i]) begin
                    trit_c[i] <= 0; pack_c[i] <= 0; hs_c[i] <= 0; pad_n[i] <= 0;
                    done_c[i] <= 0; since[i] <= 0; init_c[i] <= init_c[i] + 1;
                end else begin
                    if (trit_en[i]) trit_c[i] <= trit_c[i] + 1;
                    if (pack_load[i]) begin
                        pack_c[i] <= pack_c[i] + 1;
                        if (since[i] != 5) viol_pack[i] <= viol_pack[i] + 1;
                        since[i] <= 0;
                    end else if (trit_en[i]) begin
                        since[i] <= since[i] + 1;
                    end
                    if (hash_start[i]) begin
                        hs_c[i] <= hs_c[i] + 1;
                        if (hs_c[i] < 4) hsl_log[i][hs_c[i]] <= hash_last[i];
                    end
                    if (pad_sel[i] && blk_shift[i] && pad_n[i] < 256) begin
                        pad_log[i][pad_n[i]] <= pb[i];
                        pad_n[i] <= pad_n[i] + 1;
                    end
                    if (done[i]) done_c[i] <= done_c[i] + 1;
                end
                if ((rnd_ready[i] && (pack_load[i] || blk_shift[i])) || (trit_en[i] && !rnd_ready[i]))
                    viol_rdy[i] <= viol_rdy[i] + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_msg(input int i, input bit toggle, input int budget, output bit timeout);
        start[i] = 1'b1;
        tick();
        start[i] = 1'b0;
        timeout = 1'b1;
        for (int c = 0; c < budget; c++) begin
            if (toggle) rnd_valid = ~rnd_valid;
            tick();
            if (done[i]) begin
                timeout = 1'b0;
                break;
            end
        end
        rnd_valid = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        rnd_valid = 1'b1;
        repeat (3) tick();
        checks++; if (busy !== 3'b000) begin errors++; $display("FAIL reset_busy: got %b want 000", busy); end
        checks++; if (done !== 3'b000) begin errors++; $display("FAIL reset_done: got %b want 000", done); end
        checks++; if ({rnd_ready, trit_en} !== 6'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", {rnd_ready, trit_en}); end
        checks++; if ({hash_init, hash_start, hash_last} !== 9'b0) begin errors++; $display("FAIL reset_hash: got %b want 0", {hash_init, hash_start, hash_last}); end
        checks++; if ({trit_clr, pack_load, blk_shift, blk_clr, pad_sel} !== 15'b0) begin errors++; $display("FAIL reset_enables: got %b want 0", {trit_clr, pack_load, blk_shift, blk_clr, pad_sel}); end
        checks++; if (pb[0] !== 8'h00) begin errors++; $display("FAIL reset_pad_byte: got %h want 00", pb[0]); end
        checks++; if (bc_a !== 8'd0) begin errors++; $display("FAIL reset_byte_cnt: got %0d want 0", bc_a); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_default(input string tag);
        bit to;
        int nz;
        busy_len = 24;
        run_msg(0, 1'b0, 4000, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL %s_timeout: no done within budget", tag); end
        checks++; if (trit_c[0] !== 700) begin errors++; $display("FAIL %s_trit_en: got %0d want 700", tag, trit_c[0]); end
        checks++; if (pack_c[0] !== 140) begin errors++; $display("FAIL %s_pack_load: got %0d want 140", tag, pack_c[0]); end
        checks++; if (hs_c[0] !== 2) begin errors++; $display("FAIL %s_hash_start: got %0d want 2", tag, hs_c[0]); end
        checks++; if ({hsl_log[0][0], hsl_log[0][1]} !== 2'b01) begin errors++; $display("FAIL %s_hash_last: got %b want 01", tag, {hsl_log[0][0], hsl_log[0][1]}); end
        checks++; if (pad_n[0] !== 132) begin errors++; $display("FAIL %s_pad_len: got %0d want 132", tag, pad_n[0]); end
        checks++; if (pad_log[0][0] !== 8'h06) begin errors++; $display("FAIL %s_pad_first: got %h want 06", tag, pad_log[0][0]); end
        checks++; if (pad_log[0][131] !== 8'h80) begin errors++; $display("FAIL %s_pad_last: got %h want 80", tag, pad_log[0][131]); end
        nz = 0;
        for (int k = 1; k < 131; k++) if (pad_log[0][k] !== 8'h00) nz++;
        checks++; if (nz !== 0) begin errors++; $display("FAIL %s_pad_mid: got %0d nonzero want 0", tag, nz); end
        checks++; if (done_c[0] !== 1) begin errors++; $display("FAIL %s_done_count: got %0d want 1", tag, done_c[0]); end
        checks++; if (bc_a !== 8'd140) begin errors++; $display("FAIL %s_byte_cnt: got %0d want 140", tag, bc_a); end
        checks++; if ({busy[0], hash_last[0]} !== 2'b00) begin errors++; $display("FAIL %s_idle_after: got %b want 00", tag, {busy[0], hash_last[0]}); end
    endtask

    task automatic test_full_block_pad();
        bit to;
        int nz;
        busy_len = 24;
        run_msg(1, 1'b0, 1000, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL fullpad_timeout: no done within budget"); end
        checks++; if (hs_c[1] !== 2) begin errors++; $display("FAIL fullpad_hash_start: got %0d want 2", hs_c[1]); end
        checks++; if ({hsl_log[1][0], hsl_log[1][1]} !== 2'b01) begin errors++; $display("FAIL fullpad_hash_last: got %b want 01", {hsl_log[1][0], hsl_log[1][1]}); end
        checks++; if (pad_n[1] !== 8) begin errors++; $display("FAIL fullpad_len: got %0d want 8", pad_n[1]); end
        checks++; if ({pad_log[1][0], pad_log[1][7]} !== 16'h0680) begin errors++; $display("FAIL fullpad_ends: got %h want 0680", {pad_log[1][0], pad_log[1][7]}); end
        nz = 0;
        for (int k = 1; k < 7; k++) if (pad_log[1][k] !== 8'h00) nz++;
        checks++; if (nz !== 0) begin errors++; $display("FAIL fullpad_mid: got %0d nonzero want 0", nz); end
        checks++; if (pack_c[1] !== 8 || bc_b !== 4'd8) begin errors++; $display("FAIL fullpad_bytes: got %0d/%0d want 8/8", pack_c[1], bc_b); end
    endtask

    task automatic test_single_pad();
        bit to;
        busy_len = 24;
        run_msg(2, 1'b0, 1000, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL onepad_timeout: no done within budget"); end
        checks++; if (pad_n[2] !== 1) begin errors++; $display("FAIL onepad_len: got %0d want 1", pad_n[2]); end
        checks++; if (pad_log[2][0] !== 8'h86) begin errors++; $display("FAIL onepad_byte: got %h want 86", pad_log[2][0]); end
        checks++; if (hs_c[2] !== 1 || hsl_log[2][0] !== 1'b1) begin errors++; $display("FAIL onepad_absorb: got %0d/%b want 1/1", hs_c[2], hsl_log[2][0]); end
        checks++; if (done_c[2] !== 1) begin errors++; $display("FAIL onepad_done: got %0d want 1", done_c[2]); end
    endtask

    task automatic test_rnd_toggle();
        bit to;
        int vp, vr;
        busy_len = 24;
        vp = viol_pack[0];
        vr = viol_rdy[0];
        run_msg(0, 1'b1, 6000, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL toggle_timeout: no done within budget"); end
        checks++; if (trit_c[0] !== 700 || pack_c[0] !== 140) begin errors++; $display("FAIL toggle_counts: got %0d/%0d want 700/140", trit_c[0], pack_c[0]); end
        checks++; if (viol_pack[0] - vp !== 0) begin errors++; $display("FAIL toggle_trits_per_byte: got %0d bad packs want 0", viol_pack[0] - vp); end
        checks++; if (viol_rdy[0] - vr !== 0) begin errors++; $display("FAIL toggle_ready: got %0d bad cycles want 0", viol_rdy[0] - vr); end
    endtask

    task automatic test_hash_stall();
        bit seen, to;
        int bad, ic;
        busy_len = 30;
        ic = init_c[0];
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 2000 && !seen; c++) begin
            tick();
            if (hash_start[0]) seen = 1'b1;
        end
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL stall_absorb: no hash_start within budget"); end
        tick();
        bad = 0;
        for (int c = 0; c < 28; c++) begin
            start[0] = (c >= 5 && c < 8);
            if (rnd_ready[0] || !busy[0] || blk_shift[0] || hash_init[0] || bc_a != 8'd136) bad++;
            tick();
        end
        start[0] = 1'b0;
        checks++; if (bad !== 0) begin errors++; $display("FAIL stall_wait: got %0d bad cycles want 0", bad); end
        to = 1'b1;
        for (int c = 0; c < 2000 && to; c++) begin
            tick();
            if (done[0]) to = 1'b0;
        end
        tick();
        tick();
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL stall_timeout: no done within budget"); end
        checks++; if (init_c[0] - ic !== 1) begin errors++; $display("FAIL stall_start_ignored: got %0d inits want 1", init_c[0] - ic); end
        checks++; if (pack_c[0] !== 140 || hs_c[0] !== 2 || done_c[0] !== 1) begin errors++; $display("FAIL stall_run: got %0d/%0d/%0d want 140/2/1", pack_c[0], hs_c[0], done_c[0]); end
        busy_len = 24;
    endtask

    task automatic test_reset_mid();
        bit hit;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 1000 && !hit; c++) begin
            tick();
            if (bc_a == 8'd50 && rnd_ready[0]) hit = 1'b1;
        end
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL rstmid_reach: byte 50 not reached"); end
        rst = 1'b0;
        #1;
        checks++; if ({busy[0], done[0], rnd_ready[0], trit_en[0], trit_clr[0], pack_load[0], blk_shift[0], blk_clr[0], pad_sel[0], hash_init[0], hash_start[0], hash_last[0]} !== 12'b0) begin
            errors++; $display("FAIL rstmid_pulses: got %b want 0", {busy[0], done[0], rnd_ready[0], trit_en[0], trit_clr[0], pack_load[0], blk_shift[0], blk_clr[0], pad_sel[0], hash_init[0], hash_start[0], hash_last[0]});
        end
        checks++; if (bc_a !== 8'd0 || pb[0] !== 8'h00) begin errors++; $display("FAIL rstmid_data: got %0d/%h want 0/00", bc_a, pb[0]); end
        tick();
        tick();
        rst = 1'b1;
        tick();
        test_default("rerun");
    endtask

    initial begin
        test_reset();
        test_default("default");
        test_full_block_pad();
        test_single_pad();
        test_rnd_toggle();
        test_hash_stall();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
